bmr_loader: RTL and testbench

Bitmap-register loader: fills the 1536-bit bitmap register (64 rows × 24 px) that the ALU shift/scale datapath reads as `bmr`. On a `start` command it fetches 96 consecutive 16-bit words from data memory and assembles them into a staging register. It then commits the full bitmap to `bmr` in a single cycle. It sits between the LD-bitmap decode path and data memory, on the write side of the bitmap register.

---
 rtl/bm_pkg.sv | 19 +
 rtl/bmr_loader.sv | 113 +++++++++++
 tb/tb_bmr_loader.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bm_pkg.sv
// Shared bitmap constants, bitmap type and loader state encoding.
// Imported by the bitmap loader and the ALU bitmap ports.
package bm_pkg;

    localparam int BM_ROWS  = 64;
    localparam int BM_COLS  = 24;
    localparam int BM_W     = BM_ROWS * BM_COLS;
    localparam int BM_WORDS = 96;

    typedef logic [BM_W-1:0] bm_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } ld_state_e;

endpackage

// File: rtl/bmr_loader.sv
// Bitmap-register loader: fetches BM_WORDS words into a staging register,
// then commits the whole bitmap to bmr in one cycle.
module bmr_loader
    import bm_pkg::*;
#(
    parameter int WORD_W   = 16,
    parameter int BM_W     = 1536,
    parameter int BM_WORDS = 96,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_valid,
    input  logic [WORD_W-1:0] mem_rd_data,
    output logic [BM_W-1:0]   bmr,
    output logic              bmr_we
);

    localparam logic [6:0] LAST = 7'(BM_WORDS - 1);

    ld_state_e         state_q;
    logic [6:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [BM_W-1:0]   stage_q;
    logic [BM_W-1:0]   stage_d;
    logic [BM_W-1:0]   bmr_q;
    logic              busy_q;
    logic              done_q;
    logic              bmr_we_q;
    logic              rd_en_q;

    // Indexed part-select insert of the returning word.
    always_comb begin
        stage_d = stage_q;
        if (state_q == ST_WAIT && mem_rd_valid) begin
            stage_d[cnt_q*WORD_W +: WORD_W] = mem_rd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            mem_addr_q <= '0;
            stage_q    <= '0;
            bmr_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bmr_we_q   <= 1'b0;
            rd_en_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            bmr_we_q <= 1'b0;
            rd_en_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_q     <= base_addr;
                        cnt_q      <= '0;
                        mem_addr_q <= base_addr;
                        rd_en_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_rd_valid) begin
                        stage_q <= stage_d;
                        cnt_q   <= cnt_q + 7'd1;
                        // Commit on entry so bmr is new while done is high.
                        if (cnt_q == LAST) begin
                            bmr_q    <= stage_d;
                            done_q   <= 1'b1;
                            bmr_we_q <= 1'b1;
                            state_q  <= ST_DONE;
                        end else begin
                            mem_addr_q <= addr_q + ADDR_W'(cnt_q) + 1'b1;
                            rd_en_q    <= 1'b1;
                            state_q    <= ST_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign bmr_we    = bmr_we_q;
    assign mem_rd_en = rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign bmr       = bmr_q;

endmodule

// File: tb/tb_bmr_loader.sv
// Scoreboard bench for bmr_loader: memory model with variable latency,
// expected strobes and commits queued by stimulus, checked by a monitor.
module tb_bmr_loader;
    import bm_pkg::*;

    typedef struct {
        int          cycle;
        logic [1535:0] bm;
    } done_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   base_addr;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [15:0]   mem_addr;
    logic          mem_rd_valid = 1'b0;
    logic [15:0]   mem_rd_data = '0;
    logic [1535:0] bmr;
    logic          bmr_we;

    bmr_loader #(
        .WORD_W(16), .BM_W(1536), .BM_WORDS(96), .ADDR_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rd_valid(mem_rd_valid),
        .mem_rd_data(mem_rd_data), .bmr(bmr), .bmr_we(bmr_we)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_seen = 0;

    always @(posedge clk) cyc++;

    // Memory model: one return per strobe, latency mem_lat cycles.
    int          mem_lat = 1;
    bit          mem_fixed = 1'b0;
    logic [15:0] mem_base = '0;
    int          cd = 0;
    logic [15:0] pend_addr = '0;
    bit          stale_inj = 1'b0;
    bit          mem_flush = 1'b0;

    always @(negedge clk) begin
        mem_rd_valid = 1'b0;
        if (mem_flush) begin
            cd = 0;
            mem_flush = 1'b0;
        end
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                mem_rd_valid = 1'b1;
                mem_rd_data = mem_fixed ? 16'h5A5A
                                        : 16'hA000 + (pend_addr - mem_base);
            end
        end
        if (stale_inj) begin
            mem_rd_valid = 1'b1;
            mem_rd_data = 16'hDEAD;
            stale_inj = 1'b0;
        end
        if (mem_rd_en === 1'b1) begin
            cd = mem_lat;
            pend_addr = mem_addr;
        end
    end

    // Scoreboard monitor
    logic [15:0]   exp_addr[$];
    done_t         exp_done[$];
    logic [1535:0] cur_bmr = '0;
    logic [15:0]   ea;
    done_t         ed;

    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            cur_bmr = '0;
        end else begin
            if (mem_rd_en) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_extra got addr=%h exp none", mem_addr);
                end else begin
                    ea = exp_addr.pop_front();
                    if (mem_addr !== ea) begin
                        errors++;
                        $display("FAIL strobe_addr got=%h exp=%h", mem_addr, ea);
                    end
                end
                checks++;
                if (bmr !== cur_bmr) begin
                    errors++;
                    $display("FAIL bmr_hold got[63:0]=%h exp[63:0]=%h",
                             bmr[63:0], cur_bmr[63:0]);
                end
            end
            if (done) begin
                done_seen++;
                checks++;
                if (exp_done.size() == 0) begin
                    errors++;
                    $display("FAIL done_extra got done=1 exp none");
                end else begin
                    ed = exp_done.pop_front();
                    if (cyc - start_cyc != ed.cycle) begin
                        errors++;
                        $display("FAIL done_cycle got=%0d exp=%0d",
                                 cyc - start_cyc, ed.cycle);
                    end
                    checks++;
                    if (bmr !== ed.bm) begin
                        errors++;
                        $display("FAIL bmr_value got[63:0]=%h exp[63:0]=%h hi got=%h exp=%h",
                                 bmr[63:0], ed.bm[63:0], bmr[1535:1520], ed.bm[1535:1520]);
                    end
                    checks++;
                    if (bmr_we !== 1'b1 || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL done_flags got we=%b busy=%b exp we=1 busy=1",
                                 bmr_we, busy);
                    end
                    cur_bmr = ed.bm;
                end
            end else begin
                if (bmr_we !== 1'b0) begin
                    checks++;
                    errors++;
                    $display("FAIL we_without_done got=%b exp=0", bmr_we);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic queue_load(input logic [15:0] base, input int lat,
                              input bit fixed);
        logic [1535:0] e;
        done_t d;
        e = '0;
        for (int k = 0; k < 96; k++) begin
            e[16*k +: 16] = fixed ? 16'h5A5A : 16'hA000 + 16'(k);
            exp_addr.push_back(base + 16'(k));
        end
        d.cycle = 96 * (lat + 1) + 1;
        d.bm = e;
        exp_done.push_back(d);
        mem_lat = lat;
        mem_fixed = fixed;
        mem_base = base;
        base_addr = base;
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic load(input logic [15:0] base, input int lat,
                        input bit fixed, input bit mid_start);
        int target;
        int budget;
        bit seen;
        target = done_seen + 1;
        budget = 96 * (lat + 1) + 20;
        seen = 1'b0;
        queue_load(base, lat, fixed);
        for (int i = 0; i < budget; i++) begin
            start = (mid_start && (cyc - start_cyc == 50));
            base_addr = mid_start ? 16'h7777 : base;
            tick();
            start = 1'b0;
            if (done_seen >= target) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL load_timeout got done_seen=%0d exp=%0d",
                     done_seen, target);
        end
        tick();
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("strobes_left", 64'(exp_addr.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_bmr_we", 64'(bmr_we), 64'd0);
        chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_bmr", 64'(bmr != '0), 64'd0);
        rst = 1'b0;
        tick();

        stale_inj = 1'b1;
        repeat (2) tick();
        stale_inj = 1'b1;
        repeat (3) tick();
        chk("idle_valid_bmr", 64'(bmr != '0), 64'd0);
        chk("idle_valid_busy", 64'(busy), 64'd0);

        load(16'h0100, 1, 1'b0, 1'b0);
        load(16'h0100, 3, 1'b0, 1'b0);
        load(16'hFFF0, 1, 1'b0, 1'b0);
        load(16'h0200, 1, 1'b1, 1'b1);

        queue_load(16'h0300, 1, 1'b0);
        for (int i = 0; i < 200 && (cyc - start_cyc) < 100; i++) tick();
        rst = 1'b1;
        stale_inj = 1'b1;
        mem_flush = 1'b1;
        exp_addr.delete();
        exp_done.delete();
        tick();
        chk("midrst_bmr", 64'(bmr != '0), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_rd_en", 64'(mem_rd_en), 64'd0);
        rst = 1'b0;
        tick();
        chk("stale_busy", 64'(busy), 64'd0);
        chk("stale_rd_en", 64'(mem_rd_en), 64'd0);
        chk("stale_bmr", 64'(bmr != '0), 64'd0);
        repeat (2) tick();

        load(16'h1234, 2, 1'b1, 1'b0);
        chk("final_word0", 64'(bmr[15:0]), 64'h5A5A);

        repeat (4) tick();
        chk("done_queue_empty", 64'(exp_done.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
